// File: rtl/vc_outport.sv
// Output-port VC manager: allocates downstream VCs, tracks per-VC credits,
// rewrites the VID field and launches flits onto the link when a credit is held.
module vc_outport #(
  parameter int D_WIDTH     = 32,
  parameter int VID_BITS    = 6,
  parameter int NUM_VC      = 4,
  parameter int BUF_DEPTH   = 8,
  parameter int CREDIT_BITS = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            va_req,
  output logic                            va_gnt,
  output logic [VID_BITS-1:0]             va_ovid,
  input  logic                            st_valid,
  input  logic [VID_BITS-1:0]             st_ovid,
  input  logic [D_WIDTH-1:0]              st_flit,
  output logic                            st_ready,
  output logic                            link_valid,
  output logic [D_WIDTH-1:0]              link_flit,
  input  logic                            credit_valid,
  input  logic [VID_BITS-1:0]             credit_vid,
  output logic [NUM_VC-1:0]               vc_busy,
  output logic [NUM_VC*CREDIT_BITS-1:0]   g_credits,
  output logic                            err_credit
);

  localparam int IDX_W    = (NUM_VC > 1) ? $clog2(NUM_VC) : 1;
  localparam int TYPE_LSB = D_WIDTH - VID_BITS - 2;
  localparam logic [CREDIT_BITS-1:0] CRED_MAX  = CREDIT_BITS'(BUF_DEPTH);
  localparam logic [1:0]             TYPE_TAIL = 2'b01;

  typedef enum logic {
    VC_IDLE   = 1'b0,
    VC_ACTIVE = 1'b1
  } vc_state_e;

  vc_state_e              state_q [NUM_VC];
  vc_state_e              state_d [NUM_VC];
  logic [CREDIT_BITS-1:0] cred_q  [NUM_VC];
  logic [CREDIT_BITS-1:0] cred_d  [NUM_VC];
  logic                   link_valid_q, link_valid_d;
  logic [D_WIDTH-1:0]     link_flit_q, link_flit_d;
  logic                   err_q, err_d;

  logic                   gnt_found;
  logic [IDX_W-1:0]       gnt_idx;
  logic                   st_in_range;
  logic [IDX_W-1:0]       st_idx;
  logic                   cr_in_range;
  logic [IDX_W-1:0]       cr_idx;
  logic                   accept;
  logic                   st_is_tail;

  // Lowest-index idle VC; state only, so a VC freed this cycle is not visible yet.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int i = NUM_VC - 1; i >= 0; i--) begin
      if (state_q[i] == VC_IDLE) begin
        gnt_found = 1'b1;
        gnt_idx   = IDX_W'(i);
      end
    end
  end

  assign va_gnt  = va_req & gnt_found;
  assign va_ovid = va_gnt ? VID_BITS'(gnt_idx) : '0;

  assign st_in_range = (32'(st_ovid) < NUM_VC);
  assign st_idx      = st_ovid[IDX_W-1:0];
  assign cr_in_range = (32'(credit_vid) < NUM_VC);
  assign cr_idx      = credit_vid[IDX_W-1:0];

  always_comb begin
    st_ready = 1'b0;
    if (st_in_range) begin
      st_ready = (state_q[st_idx] == VC_ACTIVE) && (cred_q[st_idx] != '0);
    end
  end

  assign accept     = st_valid & st_ready;
  assign st_is_tail = (st_flit[TYPE_LSB +: 2] == TYPE_TAIL);

  // Per-VC ownership and credit update; a send and a credit on the same VC cancel.
  always_comb begin
    logic send_v;
    logic ret_v;
    send_v = 1'b0;
    ret_v  = 1'b0;
    err_d  = credit_valid & ~cr_in_range;
    for (int i = 0; i < NUM_VC; i++) begin
      state_d[i] = state_q[i];
      cred_d[i]  = cred_q[i];
      send_v     = accept && (st_idx == IDX_W'(i));
      ret_v      = credit_valid && cr_in_range && (cr_idx == IDX_W'(i));
      if (va_gnt && (gnt_idx == IDX_W'(i))) begin
        state_d[i] = VC_ACTIVE;
      end
      if (send_v && st_is_tail) begin
        state_d[i] = VC_IDLE;
      end
      if (send_v && !ret_v) begin
        cred_d[i] = cred_q[i] - 1'b1;
      end else if (ret_v && !send_v) begin
        if (cred_q[i] < CRED_MAX) begin
          cred_d[i] = cred_q[i] + 1'b1;
        end else begin
          err_d = 1'b1;
        end
      end
    end
  end

  always_comb begin
    link_valid_d = accept;
    link_flit_d  = link_flit_q;
    if (accept) begin
      link_flit_d = {st_ovid, st_flit[D_WIDTH-VID_BITS-1:0]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_VC; i++) begin
        state_q[i] <= VC_IDLE;
        cred_q[i]  <= CRED_MAX;
      end
      link_valid_q <= 1'b0;
      link_flit_q  <= '0;
      err_q        <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_VC; i++) begin
        state_q[i] <= state_d[i];
        cred_q[i]  <= cred_d[i];
      end
      link_valid_q <= link_valid_d;
      link_flit_q  <= link_flit_d;
      err_q        <= err_d;
    end
  end

  always_comb begin
    vc_busy   = '0;
    g_credits = '0;
    for (int i = 0; i < NUM_VC; i++) begin
      vc_busy[i]                             = (state_q[i] == VC_ACTIVE);
      g_credits[i*CREDIT_BITS +: CREDIT_BITS] = cred_q[i];
    end
  end

  assign link_valid = link_valid_q;
  assign link_flit  = link_flit_q;
  assign err_credit = err_q;

endmodule

// File: tb/tb_vc_outport.sv
// Directed bench for vc_outport: scoreboard of expected link flits plus
// direct checks of grants, credits, busy flags and error pulses.
module tb_vc_outport;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        va_req = 1'b0;
  logic        va_gnt;
  logic [5:0]  va_ovid;
  logic        st_valid = 1'b0;
  logic [5:0]  st_ovid = '0;
  logic [31:0] st_flit = '0;
  logic        st_ready;
  logic        link_valid;
  logic [31:0] link_flit;
  logic        credit_valid = 1'b0;
  logic [5:0]  credit_vid = '0;
  logic [3:0]  vc_busy;
  logic [15:0] g_credits;
  logic        err_credit;

  int checks = 0;
  int failures = 0;
  logic [31:0] sb[$];

  vc_outport dut (
    .clk(clk), .rst_n(rst_n),
    .va_req(va_req), .va_gnt(va_gnt), .va_ovid(va_ovid),
    .st_valid(st_valid), .st_ovid(st_ovid), .st_flit(st_flit), .st_ready(st_ready),
    .link_valid(link_valid), .link_flit(link_flit),
    .credit_valid(credit_valid), .credit_vid(credit_vid),
    .vc_busy(vc_busy), .g_credits(g_credits), .err_credit(err_credit)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Each link flit is compared against the oldest expected entry.
  always @(negedge clk) begin
    if (rst_n && link_valid) begin
      if (sb.size() == 0) chk("sb_unexpected_flit", 64'(link_flit), 64'hDEAD);
      else chk("link_flit", 64'(link_flit), 64'(sb.pop_front()));
    end
  end

  task automatic cyc(input logic va, input logic eg, input logic [5:0] eo,
                     input logic sv, input logic [5:0] so, input logic [31:0] sf,
                     input logic er, input logic cv, input logic [5:0] cvid);
    @(negedge clk);
    va_req = va; st_valid = sv; st_ovid = so; st_flit = sf;
    credit_valid = cv; credit_vid = cvid;
    #1;
    if (va) begin
      chk("va_gnt", 64'(va_gnt), 64'(eg));
      chk("va_ovid", 64'(va_ovid), 64'(eo));
    end
    if (sv) begin
      chk("st_ready", 64'(st_ready), 64'(er));
      if (er) sb.push_back({so, sf[25:0]});
    end
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 6'd0, 1'b0, 6'd0, 32'd0, 1'b0, 1'b0, 6'd0);
  endtask

  task automatic req(input logic eg, input logic [5:0] eo);
    cyc(1'b1, eg, eo, 1'b0, 6'd0, 32'd0, 1'b0, 1'b0, 6'd0);
  endtask

  task automatic send(input logic [5:0] so, input logic [31:0] sf, input logic er);
    cyc(1'b0, 1'b0, 6'd0, 1'b1, so, sf, er, 1'b0, 6'd0);
  endtask

  task automatic credit(input logic [5:0] vid);
    cyc(1'b0, 1'b0, 6'd0, 1'b0, 6'd0, 32'd0, 1'b0, 1'b1, vid);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    va_req = 0; st_valid = 0; credit_valid = 0;
    rst_n = 1'b0;
    #1;
    chk("rst_vc_busy", 64'(vc_busy), 64'h0);
    chk("rst_credits", 64'(g_credits), 64'h8888);
    chk("rst_link_valid", 64'(link_valid), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    // Power-on reset state
    #1;
    chk("por_link_flit", 64'(link_flit), 64'h0);
    chk("por_err", 64'(err_credit), 64'h0);
    do_reset();

    // Grants walk 0..3 then run out
    for (int i = 0; i < 4; i++) req(1'b1, 6'(i));
    req(1'b0, 6'd0);
    idle();
    chk("busy_all", 64'(vc_busy), 64'hF);

    // VC 2: eight flits drain all credits, ninth waits for a returned credit
    do_reset();
    for (int i = 0; i < 3; i++) req(1'b1, 6'(i));
    for (int k = 0; k < 8; k++) send(6'd2, {6'h3F, 2'b10, 24'(k * 3 + 1)}, 1'b1);
    send(6'd2, {6'h15, 2'b10, 24'hABCDE}, 1'b0);
    chk("vc2_credits_zero", 64'(g_credits[11:8]), 64'd0);
    cyc(1'b0, 1'b0, 6'd0, 1'b1, 6'd2, {6'h15, 2'b10, 24'hABCDE}, 1'b0, 1'b1, 6'd2);
    send(6'd2, {6'h15, 2'b10, 24'hABCDE}, 1'b1);
    idle();
    chk("vc2_credits_after", 64'(g_credits[11:8]), 64'd0);
    chk("vc2_no_err", 64'(err_credit), 64'd0);

    // Credit overflow and out-of-range credit VID
    do_reset();
    credit(6'd1);
    idle();
    chk("ovf_err", 64'(err_credit), 64'd1);
    chk("ovf_credits", 64'(g_credits), 64'h8888);
    idle();
    chk("ovf_err_clear", 64'(err_credit), 64'd0);
    credit(6'd5);
    idle();
    chk("badvid_err", 64'(err_credit), 64'd1);
    chk("badvid_credits", 64'(g_credits), 64'h8888);
    idle();
    chk("badvid_err_clear", 64'(err_credit), 64'd0);

    // VC 0: simultaneous send and credit leaves the counter unchanged
    do_reset();
    req(1'b1, 6'd0);
    for (int k = 0; k < 8; k++) send(6'd0, {6'h00, 2'b10, 24'(32'h100 + k)}, 1'b1);
    idle();
    chk("vc0_zero", 64'(g_credits[3:0]), 64'd0);
    credit(6'd0);
    idle();
    chk("vc0_one", 64'(g_credits[3:0]), 64'd1);
    cyc(1'b0, 1'b0, 6'd0, 1'b1, 6'd0, {6'h07, 2'b10, 24'h777}, 1'b1, 1'b1, 6'd0);
    idle();
    chk("vc0_same", 64'(g_credits[3:0]), 64'd1);
    chk("vc0_same_err", 64'(err_credit), 64'd0);

    // Packet on VC 0, release on tail, and blocked sends
    do_reset();
    req(1'b1, 6'd0);
    send(6'd4, {6'h00, 2'b11, 24'h4}, 1'b0);
    send(6'd2, {6'h00, 2'b11, 24'h2}, 1'b0);
    send(6'd0, {6'h2A, 2'b11, 24'h111}, 1'b1);
    send(6'd0, {6'h2A, 2'b10, 24'h222}, 1'b1);
    cyc(1'b1, 1'b1, 6'd1, 1'b1, 6'd0, {6'h2A, 2'b01, 24'h333}, 1'b1, 1'b0, 6'd0);
    req(1'b1, 6'd0);
    chk("tail_busy", 64'(vc_busy), 64'h2);
    idle();
    chk("realloc_busy", 64'(vc_busy), 64'h3);
    chk("vc0_credits_pkt", 64'(g_credits[3:0]), 64'd5);

    // Reset in the middle of a packet on VC 3
    do_reset();
    for (int i = 0; i < 4; i++) req(1'b1, 6'(i));
    send(6'd3, {6'h01, 2'b11, 24'h300}, 1'b1);
    for (int k = 0; k < 5; k++) send(6'd3, {6'h01, 2'b10, 24'(32'h301 + k)}, 1'b1);
    @(negedge clk);
    st_valid = 1'b1; st_ovid = 6'd3; st_flit = {6'h01, 2'b10, 24'h3FF};
    #2;
    chk("pre_rst_credits", 64'(g_credits[15:12]), 64'd2);
    chk("pre_rst_link_valid", 64'(link_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_link_valid", 64'(link_valid), 64'd0);
    chk("mid_rst_credits", 64'(g_credits), 64'h8888);
    chk("mid_rst_busy", 64'(vc_busy), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    send(6'd3, {6'h01, 2'b10, 24'h3FF}, 1'b0);
    idle();
    chk("post_rst_link_valid", 64'(link_valid), 64'd0);
    idle();
    chk("post_rst_link_valid2", 64'(link_valid), 64'd0);
    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vc_outport.md
# vc_outport

Output-port side of the router's virtual-channel protocol: owns the downstream input buffers' credit state for one output link. Allocates free output VCs to winning input VCs, stamps the output VID onto each flit, launches flits onto the link only when the target VC holds a credit, and releases the VC on tail. It sits between the switch traversal stage and the physical link; the downstream router's input buffer returns one credit per flit it drains.

## Interface
- D_WIDTH, 32: flit width; VID field is flit[D_WIDTH-1 -: VID_BITS], type field is the next 2 bits (11 head, 10 body, 01 tail).
- VID_BITS, 6: VID field width; output VID = zero-extended VC index.
- NUM_VC, 4: output VCs on this link (≤ 2^VID_BITS).
- BUF_DEPTH, 8: downstream buffer depth per VC = initial/max credits.
- CREDIT_BITS, 4: counter width, ≥ clog2(BUF_DEPTH+1).

- clk  in  1  clock; one clock domain.
- rst_n  in  1  reset, asynchronous assert, active-low.
- va_req  in  1  request for a free output VC.
- va_gnt  out  1  combinational grant, same cycle as va_req.
- va_ovid  out  VID_BITS  granted VC index, valid with va_gnt.
- st_valid  in  1  flit offered for transmission.
- st_ovid  in  VID_BITS  output VC of offered flit.
- st_flit  in  D_WIDTH  offered flit.
- st_ready  out  1  combinational: target VC busy and credits > 0.
- link_valid  out  1  registered flit valid to downstream.
- link_flit  out  D_WIDTH  registered flit, VID field replaced by st_ovid.
- credit_valid  in  1  one credit returned from downstream.
- credit_vid  in  VID_BITS  VC receiving the credit.
- vc_busy  out  NUM_VC  per-VC allocated flag.
- g_credits  out  NUM_VC*CREDIT_BITS  per-VC counters, VC i at [i*CREDIT_BITS +: CREDIT_BITS].
- err_credit  out  1  one-cycle pulse on credit overflow or out-of-range VID.

## Operation
- Per-VC state: IDLE (vc_busy=0) / ACTIVE (vc_busy=1).
- IDLE→ACTIVE: va_req=1 and VC is the lowest-index IDLE VC → va_gnt=1, va_ovid=index; state updates at next edge. No IDLE VC → va_gnt=0, va_ovid=0.
- ACTIVE→IDLE: accepted transfer (st_valid & st_ready) whose type field is 01. VC freed this cycle is not grantable until the following cycle.
- Transfer accept: st_ready=1 only if st_ovid < NUM_VC, VC ACTIVE, credits ≥ 1. Accepted → credits decrement; link_flit/link_valid load at next edge.
- Credit return: credit_valid & credit_vid < NUM_VC & counter < BUF_DEPTH → increment. Counter already at BUF_DEPTH (and no same-cycle send on that VC) or credit_vid ≥ NUM_VC → ignored, err_credit=1 next cycle.
- Simultaneous send and credit return on same VC: counter unchanged, no error even at BUF_DEPTH.
- Head flit on IDLE VC or st_valid to unallocated VC: st_ready=0, flit held by sender.
- Counter never wraps: decrement gated by ≥1, increment gated by <BUF_DEPTH.

## Timing
- Reset (rst_n=0, async): all counters = BUF_DEPTH, all VCs IDLE, vc_busy=0, link_valid=0, link_flit=0, err_credit=0. Reset mid-packet discards VC ownership and credits immediately; no flit is emitted after deassert until re-allocation.
- va_gnt, va_ovid, st_ready: combinational from current state, no input-to-state loop.
- Send latency: accept at edge N → link_valid=1 cycle N+1; link_valid=0 when nothing accepted.
- Credit returned at edge N is visible in st_ready and g_credits from cycle N+1.
- Back-to-back: one flit per cycle per port; sustained throughput on a VC needs round-trip ≤ BUF_DEPTH cycles.

## Test plan
- Reset then va_req held 5 cycles with no tails → grants ovid 0,1,2,3 one per cycle, 5th cycle va_gnt=0; vc_busy=4'b1111.
- Allocate VC 2, send 8 body flits with no credits back → first 8 accepted, link_flit VID=2, g_credits[2]=0, 9th st_ready=0 until one credit_valid vid 2, then accepted next cycle.
- Credit return to VC 1 at BUF_DEPTH → counter stays 8, err_credit pulses once; credit_vid=5 → err_credit pulse, no counter change.
- VC 0 at 0 credits: send accepted same cycle as credit return on VC 0 (after one credit restored) → counter unchanged, no error.
- Head/body/tail on VC 0 → vc_busy[0] clears cycle after tail; va_req in tail cycle gets lowest other idle VC, next cycle may get 0.
- Assert rst_n low mid-packet on VC 3 with credits 2 → immediately link_valid=0, counters 8, vc_busy=0; after release st_valid on VC 3 → st_ready=0.
